// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected classifier stage.
package fc_pkg;

  typedef enum logic [2:0] {StIdle, StRun, StTail, StBias, StEmit, StFin} fc_state_e;

  localparam logic [2:0]  CSEL_L2   = 3'b101;
  localparam int unsigned FRAC_BITS = 16;

  // Drop from 32 to 16 fractional bits with round-half-up, then clamp to 20-bit signed.
  function automatic logic [19:0] round_sat(input logic signed [63:0] acc);
    logic signed [63:0] r;
    r = ((acc >>> (FRAC_BITS - 1)) + 64'sd1) >>> 1;
    if (r > 64'sd524287) return 20'h7FFFF;
    if (r < -64'sd524288) return 20'h80000;
    return 20'(r);
  endfunction

  function automatic logic [14:0] weight_base(input int unsigned in_len, input logic [3:0] o);
    return 15'(in_len * 32'(o));
  endfunction

  function automatic logic [14:0] bias_addr(input int unsigned in_len, input int unsigned out_len,
                                            input logic [3:0] o);
    return 15'(in_len * out_len + 32'(o));
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Multiply-accumulate datapath for one neuron with bias add and round/saturate.
// FC_RELU_EN: when defined, negative rounded results are forced to zero.
module fc_mac
  import fc_pkg::*;
#(
  parameter int unsigned ACC_W = 44
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        mac_en_i,
  input  logic        bias_en_i,
  input  logic [19:0] feat_i,
  input  logic [19:0] wgt_i,
  output logic [19:0] res_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [39:0]      prod;
  logic signed [ACC_W-1:0] prod_ext, bias_ext;

  assign prod     = 40'($signed(feat_i)) * 40'($signed(wgt_i));
  assign prod_ext = {{(ACC_W-40){prod[39]}}, prod};
  // Bias is 4.16; shift up to the accumulator's 32 fractional bits.
  assign bias_ext = {{(ACC_W-20-FRAC_BITS){wgt_i[19]}}, wgt_i, {FRAC_BITS{1'b0}}};

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (mac_en_i) begin
      acc_d = acc_q + prod_ext;
    end else if (bias_en_i) begin
      acc_d = acc_q + bias_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Result is taken from the next-state value so it can be registered on the bias cycle.
  always_comb begin
    res_o = round_sat({{(64-ACC_W){acc_d[ACC_W-1]}}, acc_d});
`ifdef FC_RELU_EN
    if (res_o[19]) res_o = '0;
`else
`endif
  end

endmodule

// File: rtl/fc_classifier.sv
// Fully-connected output stage: sequences feature/weight reads, drives the MAC,
// emits one result per neuron and reports the arg-max class on completion.
module fc_classifier
  import fc_pkg::*;
#(
  parameter int unsigned IN_LEN  = 2048,
  parameter int unsigned OUT_LEN = 10,
  parameter int unsigned ACC_W   = 44
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        crd,
  output logic [2:0]  csel,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic        wrd,
  output logic [14:0] waddr,
  input  logic [19:0] wdata,
  output logic        res_valid,
  output logic [3:0]  res_idx,
  output logic [19:0] res_data,
  output logic        done,
  output logic [3:0]  class_idx
);

  fc_state_e   state_q;
  logic        busy_q, crd_q, wrd_q, res_valid_q, done_q, rd_vld_q;
  logic [2:0]  csel_q;
  logic [11:0] caddr_q;
  logic [14:0] waddr_q;
  logic [3:0]  o_q, res_idx_q, class_q, best_q, best_d;
  logic [19:0] res_data_q, max_q, mac_res;
  logic        upd;

  fc_mac #(
    .ACC_W(ACC_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q == StEmit),
    .mac_en_i (rd_vld_q),
    .bias_en_i(state_q == StBias),
    .feat_i   (cdata_rd),
    .wgt_i    (wdata),
    .res_o    (mac_res)
  );

  // Strict compare keeps the lowest index on ties; neuron 0 seeds the maximum.
  assign upd    = (o_q == 4'd0) || ($signed(res_data_q) > $signed(max_q));
  assign best_d = upd ? o_q : best_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      crd_q       <= 1'b0;
      wrd_q       <= 1'b0;
      csel_q      <= '0;
      caddr_q     <= '0;
      waddr_q     <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
      class_q     <= '0;
      o_q         <= '0;
      max_q       <= '0;
      best_q      <= '0;
      rd_vld_q    <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      rd_vld_q    <= crd_q;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            crd_q   <= 1'b1;
            wrd_q   <= 1'b1;
            csel_q  <= CSEL_L2;
            caddr_q <= '0;
            waddr_q <= '0;
            o_q     <= '0;
          end
        end
        StRun: begin
          if (caddr_q == 12'(IN_LEN - 1)) begin
            state_q <= StTail;
            crd_q   <= 1'b0;
            csel_q  <= '0;
            caddr_q <= '0;
            waddr_q <= bias_addr(IN_LEN, OUT_LEN, o_q);
          end else begin
            caddr_q <= caddr_q + 12'd1;
            waddr_q <= waddr_q + 15'd1;
          end
        end
        StTail: begin
          state_q <= StBias;
          wrd_q   <= 1'b0;
          waddr_q <= '0;
        end
        StBias: begin
          state_q     <= StEmit;
          res_valid_q <= 1'b1;
          res_idx_q   <= o_q;
          res_data_q  <= mac_res;
        end
        StEmit: begin
          if (upd) max_q <= res_data_q;
          best_q <= best_d;
          if (o_q == 4'(OUT_LEN - 1)) begin
            state_q <= StFin;
            done_q  <= 1'b1;
            class_q <= best_d;
          end else begin
            state_q <= StRun;
            o_q     <= o_q + 4'd1;
            crd_q   <= 1'b1;
            wrd_q   <= 1'b1;
            csel_q  <= CSEL_L2;
            caddr_q <= '0;
            waddr_q <= weight_base(IN_LEN, o_q + 4'd1);
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign crd       = crd_q;
  assign csel      = csel_q;
  assign caddr_rd  = caddr_q;
  assign wrd       = wrd_q;
  assign waddr     = waddr_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_data  = res_data_q;
  assign done      = done_q;
  assign class_idx = class_q;

endmodule

// File: tb/tb_fc_classifier.sv
// Directed bench: a 4-input instance for arithmetic/protocol vectors, a default-size
// instance for the full-length run and done-cycle timing.
module tb_fc_classifier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  // Small instance: IN_LEN=4, OUT_LEN=10
  logic        s_start = 1'b0, s_busy, s_crd, s_wrd, s_rv, s_done;
  logic [2:0]  s_csel;
  logic [11:0] s_caddr;
  logic [14:0] s_waddr;
  logic [19:0] s_cdata = '0, s_wdata = '0, s_rdata;
  logic [3:0]  s_ridx, s_cls;
  logic [19:0] feat_s[4];
  logic [19:0] wrom_s[50];

  fc_classifier #(.IN_LEN(4), .OUT_LEN(10), .ACC_W(44)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .crd(s_crd), .csel(s_csel),
    .caddr_rd(s_caddr), .cdata_rd(s_cdata), .wrd(s_wrd), .waddr(s_waddr), .wdata(s_wdata),
    .res_valid(s_rv), .res_idx(s_ridx), .res_data(s_rdata), .done(s_done), .class_idx(s_cls)
  );

  always @(posedge clk) begin
    if (s_crd) s_cdata <= feat_s[s_caddr[1:0]];
    if (s_wrd) s_wdata <= (s_waddr < 15'd50) ? wrom_s[s_waddr] : 20'hEEEEE;
  end

  // Default instance: all features zero, bias(o) = (o+1)*0x1000
  logic        b_start = 1'b0, b_busy, b_crd, b_wrd, b_rv, b_done;
  logic [2:0]  b_csel;
  logic [11:0] b_caddr;
  logic [14:0] b_waddr;
  logic [19:0] b_cdata = '0, b_wdata = '0, b_rdata;
  logic [3:0]  b_ridx, b_cls;

  fc_classifier u_big (
    .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .crd(b_crd), .csel(b_csel),
    .caddr_rd(b_caddr), .cdata_rd(b_cdata), .wrd(b_wrd), .waddr(b_waddr), .wdata(b_wdata),
    .res_valid(b_rv), .res_idx(b_ridx), .res_data(b_rdata), .done(b_done), .class_idx(b_cls)
  );

  always @(posedge clk) begin
    if (b_crd) b_cdata <= 20'h00000;
    if (b_wrd) b_wdata <= (b_waddr >= 15'd20480) ? 20'((32'(b_waddr) - 32'd20479) * 32'h1000)
                                                 : 20'h5A5A5;
  end

  int csel_bad = 0;
  always @(negedge clk) begin
    if ((s_crd && s_csel !== 3'b101) || (!s_crd && s_csel !== 3'b000) ||
        (b_crd && b_csel !== 3'b101) || (!b_crd && b_csel !== 3'b000))
      csel_bad <= csel_bad + 1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    string              name;
    logic [3:0][19:0]   f;
    logic [3:0][19:0]   w;
    int                 hot;
    logic [9:0][19:0]   b;
    logic [19:0]        exp_hot;
    logic [3:0]         exp_cls;
  } vec_t;

  function automatic vec_t mkv(input string n, input logic [79:0] f, input logic [79:0] w,
                               input int hot, input logic [199:0] b, input logic [19:0] eh,
                               input logic [3:0] ec);
    vec_t v;
    v.name = n; v.f = f; v.w = w; v.hot = hot; v.b = b; v.exp_hot = eh; v.exp_cls = ec;
    return v;
  endfunction

`ifdef FC_RELU_EN
  localparam logic [19:0] SATN_EXP = 20'h00000;
  localparam logic [19:0] NEGH_EXP = 20'h00000;
`else
  localparam logic [19:0] SATN_EXP = 20'h80000;
  localparam logic [19:0] NEGH_EXP = 20'hF8000;
`endif

  localparam logic [199:0] B0     = '0;
  localparam logic [199:0] B_TIE  = {20'h10000, 20'h10000, 20'h30000, 20'h10000, 20'h10000,
                                     20'h10000, 20'h30000, 20'h10000, 20'h10000, 20'h10000};
  localparam logic [199:0] B_RAMP = {20'h0A000, 20'h09000, 20'h08000, 20'h07000, 20'h06000,
                                     20'h05000, 20'h04000, 20'h03000, 20'h02000, 20'h01000};
  localparam logic [199:0] B_H9   = {20'h08000, 180'h0};

  logic [19:0] got_s[10];
  int          nres_s;

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < 4; k++) feat_s[k] = v.f[k];
    for (int a = 0; a < 50; a++) wrom_s[a] = '0;
    for (int k = 0; k < 4; k++) wrom_s[v.hot * 4 + k] = v.w[k];
    for (int o = 0; o < 10; o++) wrom_s[40 + o] = v.b[o];
  endtask

  // Runs one classification; cyc is the cycle index of done (start edge = cycle 0).
  task automatic run_small(input int extra_at, input bit start_at_done, output int cyc);
    nres_s = 0;
    for (int o = 0; o < 10; o++) got_s[o] = 20'hBAD00;
    @(negedge clk); s_start = 1'b1;
    @(posedge clk); #1; s_start = 1'b0;
    cyc = 1;
    chk("busy_first_cycle", 32'(s_busy), 32'd1);
    while (!s_done && cyc < 200) begin
      if (s_rv) begin
        chk("res_idx_order", 32'(s_ridx), 32'(nres_s));
        got_s[s_ridx] = s_rdata;
        nres_s++;
      end
      s_start = (cyc == extra_at);
      @(posedge clk); #1;
      cyc++;
    end
    s_start = 1'b0;
    chk("busy_in_done_cycle", 32'(s_busy), 32'd1);
    if (start_at_done) s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    chk("done_pulse_width", 32'(s_done), 32'd0);
    chk("busy_after_done", 32'(s_busy), 32'd0);
  endtask

  task automatic check_vec(input vec_t v, input int cyc);
    logic [19:0] e;
    chk({v.name, "_done_cycle"}, 32'(cyc), 32'd71);
    chk({v.name, "_nres"}, 32'(nres_s), 32'd10);
    for (int o = 0; o < 10; o++) begin
      e = (o == v.hot) ? v.exp_hot : v.b[o];
      chk($sformatf("%s_res%0d", v.name, o), 32'(got_s[o]), 32'(e));
    end
    chk({v.name, "_class"}, 32'(s_cls), 32'(v.exp_cls));
  endtask

  task automatic chk_reset_s(input string tag);
    chk({tag, "_busy"}, 32'(s_busy), 0);
    chk({tag, "_crd"}, 32'(s_crd), 0);
    chk({tag, "_wrd"}, 32'(s_wrd), 0);
    chk({tag, "_csel"}, 32'(s_csel), 0);
    chk({tag, "_caddr"}, 32'(s_caddr), 0);
    chk({tag, "_waddr"}, 32'(s_waddr), 0);
    chk({tag, "_res_valid"}, 32'(s_rv), 0);
    chk({tag, "_res_idx"}, 32'(s_ridx), 0);
    chk({tag, "_res_data"}, 32'(s_rdata), 0);
    chk({tag, "_done"}, 32'(s_done), 0);
    chk({tag, "_class"}, 32'(s_cls), 0);
  endtask

  vec_t vecs[9];

  initial begin
    int cyc;
    int bcyc;
    int nres_b;
    logic [19:0] got_b[10];

    vecs[0] = mkv("sum", {20'h08000, 20'hF0000, 20'h20000, 20'h10000}, {4{20'h10000}}, 0, B0,
                  20'h28000, 4'd0);
    vecs[1] = mkv("rnd_half", {60'h0, 20'h00001}, {60'h0, 20'h08000}, 2, B0, 20'h00001, 4'd2);
    vecs[2] = mkv("rnd_down", {60'h0, 20'h00001}, {60'h0, 20'h00001}, 0, B0, 20'h00000, 4'd0);
    vecs[3] = mkv("sat_pos", {4{20'h70000}}, {4{20'h70000}}, 5, B0, 20'h7FFFF, 4'd5);
    vecs[4] = mkv("sat_neg", {4{20'h70000}}, {4{20'h90000}}, 4, B0, SATN_EXP, 4'd0);
    vecs[5] = mkv("neg_half", {60'h0, 20'h10000}, {60'h0, 20'hF8000}, 1, B0, NEGH_EXP, 4'd0);
    vecs[6] = mkv("tie", 80'h0, 80'h0, 0, B_TIE, 20'h10000, 4'd3);
    vecs[7] = mkv("bias_ramp", 80'h0, 80'h0, 0, B_RAMP, 20'h01000, 4'd9);
    vecs[8] = mkv("hot9", {60'h0, 20'h10000}, {60'h0, 20'h20000}, 9, B_H9, 20'h28000, 4'd9);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_s("rst");

    foreach (vecs[n]) begin
      load_vec(vecs[n]);
      run_small(-1, 1'b0, cyc);
      check_vec(vecs[n], cyc);
    end

    // Extra start pulses while busy must not disturb results or timing.
    load_vec(vecs[0]);
    run_small(5, 1'b0, cyc);
    check_vec(vecs[0], cyc);

    // Start coinciding with done must be ignored.
    load_vec(vecs[8]);
    run_small(-1, 1'b1, cyc);
    check_vec(vecs[8], cyc);
    repeat (3) @(posedge clk);
    #1 chk("start_at_done_idle", 32'(s_busy), 0);

    // Reset in the middle of a run, then a clean rerun.
    load_vec(vecs[0]);
    @(negedge clk); s_start = 1'b1;
    @(posedge clk); #1; s_start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_s("midrst");
    reset = 1'b0;
    run_small(-1, 1'b0, cyc);
    check_vec(vecs[0], cyc);

    // Full-size run.
    nres_b = 0;
    for (int o = 0; o < 10; o++) got_b[o] = 20'hBAD00;
    @(negedge clk); b_start = 1'b1;
    @(posedge clk); #1; b_start = 1'b0;
    bcyc = 1;
    while (!b_done && bcyc < 21000) begin
      if (b_rv) begin
        got_b[b_ridx] = b_rdata;
        nres_b++;
      end
      @(posedge clk); #1;
      bcyc++;
    end
    chk("big_done_cycle", 32'(bcyc), 32'd20511);
    chk("big_nres", 32'(nres_b), 32'd10);
    for (int o = 0; o < 10; o++)
      chk($sformatf("big_res%0d", o), 32'(got_b[o]), 32'((o + 1) * 32'h1000));
    chk("big_class", 32'(b_cls), 32'd9);
    @(posedge clk); #1;
    chk("big_busy_after", 32'(b_busy), 0);

    chk("csel_protocol", 32'(csel_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
